// File: rtl/card_match_ctrl.sv
// card_match_ctrl -- control FSM for a 16-card memory (pairs) game.
//
// A shuffled 16 x 3-bit symbol map is latched on map_load, which also starts
// a new game. The player flips two cards; equal symbols stay up as matched,
// unequal ones are shown for HIDE_CYCLES cycles and then turned back down.
//
// Ports
//   clk, resetn      rising-edge clock, async active-low reset
//   map[0:47]        symbol map, card i = map[3i +: 3] (bit 3i is the MSB)
//   map_load         pulse: latch map, clear board, enter WAIT_FIRST
//   sel_valid/idx    player selection strobe and card index
//   sel_ready        high while a selection can be taken
//   face_up/matched  per-card revealed / matched flags
//   disp_idx/sym     combinational symbol lookup into the latched map
//   match_pulse      one-cycle strobe: pair matched
//   miss_pulse       one-cycle strobe: pair differed
//   moves            completed pair attempts, saturating at 255
//   game_won         high while in WIN
module card_match_ctrl #(
  parameter logic [25:0] HIDE_CYCLES = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [0:47] map,
  input  logic        map_load,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  output logic        sel_ready,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  input  logic [3:0]  disp_idx,
  output logic [2:0]  disp_sym,
  output logic        match_pulse,
  output logic        miss_pulse,
  output logic [7:0]  moves,
  output logic        game_won
);

  typedef enum logic [2:0] {
    IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WIN
  } state_t;

  state_t      state, state_n;
  logic [0:47] map_q, map_n;
  logic [15:0] face_n, match_n;
  logic [7:0]  moves_n;
  logic        mp_n, xp_n;
  logic [25:0] cnt, cnt_n;
  logic [3:0]  first_idx, first_n, second_idx, second_n;
  logic        accept;

  // Base bit of card i is 3*i, built as i + 2i to keep the index 6 bits wide.
  function automatic logic [2:0] sym_at(input logic [0:47] m, input logic [3:0] i);
    logic [5:0] b;
    b = {2'b00, i} + {1'b0, i, 1'b0};
    return m[b +: 3];
  endfunction

  assign sel_ready = (state == WAIT_FIRST) || (state == WAIT_SECOND);
  assign game_won  = (state == WIN);
  assign disp_sym  = sym_at(map_q, disp_idx);
  assign accept    = sel_valid && sel_ready && !face_up[sel_idx] && !matched[sel_idx];

  always_comb begin
    state_n  = state;
    map_n    = map_q;
    face_n   = face_up;
    match_n  = matched;
    moves_n  = moves;
    mp_n     = 1'b0;
    xp_n     = 1'b0;
    cnt_n    = cnt;
    first_n  = first_idx;
    second_n = second_idx;
    // map_load wins over everything, including a same-cycle selection.
    if (map_load) begin
      state_n = WAIT_FIRST;
      map_n   = map;
      face_n  = '0;
      match_n = '0;
      moves_n = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        WAIT_FIRST: if (accept) begin
          face_n[sel_idx] = 1'b1;
          first_n         = sel_idx;
          state_n         = WAIT_SECOND;
        end
        WAIT_SECOND: if (accept) begin
          face_n[sel_idx] = 1'b1;
          second_n        = sel_idx;
          if (moves != 8'hFF) moves_n = moves + 8'd1;
          state_n         = COMPARE;
        end
        COMPARE: begin
          if (sym_at(map_q, first_idx) == sym_at(map_q, second_idx)) begin
            match_n[first_idx]  = 1'b1;
            match_n[second_idx] = 1'b1;
            mp_n    = 1'b1;
            state_n = (&match_n) ? WIN : WAIT_FIRST;
          end else begin
            xp_n    = 1'b1;
            // Counts down to zero, so SHOW spans exactly HIDE_CYCLES cycles.
            cnt_n   = HIDE_CYCLES - 26'd1;
            state_n = SHOW;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            face_n[first_idx]  = 1'b0;
            face_n[second_idx] = 1'b0;
            state_n            = WAIT_FIRST;
          end else begin
            cnt_n = cnt - 26'd1;
          end
        end
        default: ;  // IDLE and WIN wait for map_load
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      map_q       <= '0;
      face_up     <= '0;
      matched     <= '0;
      moves       <= '0;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      cnt         <= '0;
      first_idx   <= '0;
      second_idx  <= '0;
    end else begin
      state       <= state_n;
      map_q       <= map_n;
      face_up     <= face_n;
      matched     <= match_n;
      moves       <= moves_n;
      match_pulse <= mp_n;
      miss_pulse  <= xp_n;
      cnt         <= cnt_n;
      first_idx   <= first_n;
      second_idx  <= second_n;
    end
  end

endmodule

// File: doc/card_match_ctrl.md
CARD_MATCH_CTRL -- requirements
Module: card_match_ctrl

Interface
REQ-001 The block SHALL have parameter HIDE_CYCLES, default 26'd50_000_000, giving the mismatch display time in clk cycles (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port map, input, [0:47], the shuffled symbol map; card i symbol = map[3i +:3], with bit 3i as MSB.
REQ-005 The block SHALL have port map_load, input, 1, a one-cycle pulse (upstream done) that latches map and starts a new game.
REQ-006 The block SHALL have port sel_valid, input, 1, a one-cycle player selection strobe.
REQ-007 The block SHALL have port sel_idx, input, 4, the selected card index 0..15.
REQ-008 The block SHALL have port sel_ready, output, 1, high in WAIT_FIRST and WAIT_SECOND only.
REQ-009 The block SHALL have port face_up, output, 16, the per-card revealed flag (bit i = card i).
REQ-010 The block SHALL have port matched, output, 16, the per-card matched flag.
REQ-011 The block SHALL have port disp_idx, input, 4, and port disp_sym, output, 3, giving combinational symbol of card disp_idx from the latched map.
REQ-012 The block SHALL have port match_pulse, output, 1, and port miss_pulse, output, 1, each a one-cycle result strobe.
REQ-013 The block SHALL have port moves, output, 8, the count of completed pair attempts, saturating at 255.
REQ-014 The block SHALL have port game_won, output, 1, held high in WIN.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WIN, registered, and SHALL leave IDLE only via map_load.
REQ-016 On map_load in any state, the next edge SHALL latch map, clear face_up, matched, moves, pulses and the delay counter, and enter WAIT_FIRST; map_load SHALL take priority over a simultaneous sel_valid.
REQ-017 A selection SHALL be accepted only when sel_valid && sel_ready && !face_up[sel_idx] && !matched[sel_idx]; otherwise it SHALL be ignored with no state change.
REQ-018 In WAIT_FIRST, an accepted selection SHALL set face_up[sel_idx], store first_idx and enter WAIT_SECOND.
REQ-019 In WAIT_SECOND, an accepted selection SHALL set face_up[sel_idx], store second_idx, increment moves (saturating) and enter COMPARE; reselecting first_idx SHALL be ignored by REQ-017.
REQ-020 COMPARE SHALL last exactly one cycle and compare the latched symbols of first_idx and second_idx.
REQ-021 On equal symbols, the block SHALL set both matched bits, pulse match_pulse for one cycle, leave face_up set, and enter WIN if all 16 matched bits are then set, else WAIT_FIRST.
REQ-022 On unequal symbols, the block SHALL pulse miss_pulse for one cycle, load the counter, and enter SHOW.
REQ-023 SHOW SHALL last exactly HIDE_CYCLES cycles, then clear face_up of both cards and enter WAIT_FIRST; sel_valid SHALL be ignored throughout.
REQ-024 WIN SHALL hold game_won=1 and ignore sel_valid until map_load or reset.
REQ-025 The result latency SHALL be: second accepted selection at edge N, match_pulse/miss_pulse high during cycle N+1 to N+2.

Reset
REQ-026 Asserting resetn low SHALL immediately and asynchronously force IDLE, face_up=0, matched=0, moves=0, match_pulse=0, miss_pulse=0, game_won=0, latched map=0, counter=0, first_idx=second_idx=0.
REQ-027 A reset asserted mid-SHOW or mid-COMPARE SHALL abort the operation with no pulse emitted after deassertion.
REQ-028 After deassertion, the block SHALL remain in IDLE (sel_ready=0) until map_load.

Verification
REQ-029 The bench SHALL check a match: map with cards 0 and 5 equal to 3'd4, map_load, select 0 then 5 -> match_pulse one cycle, matched=16'h0021, moves=1.
REQ-030 The bench SHALL check a mismatch: HIDE_CYCLES=4, select 0 then 1 with differing symbols -> miss_pulse, face_up=16'h0003 for 4 cycles, then 16'h0000, and selections during SHOW are ignored.
REQ-031 The bench SHALL check illegal selections: repeat card 0 as second pick, or pick a matched card -> no change, moves unchanged.
REQ-032 The bench SHALL check a full game: 8 correct pairs -> game_won=1, matched=16'hFFFF, moves=8, and later sel_valid is ignored.
REQ-033 The bench SHALL check priority and reset: map_load coinciding with sel_valid -> new game, face_up=0; resetn low during SHOW -> all outputs 0, IDLE.
REQ-034 The bench SHALL check saturation: 260 mismatched attempts -> moves=255.
